// File: rtl/box_plot_scheduler.sv
// Round-robin arbiter that shares one VGA pixel-write port between NREQ box engines.
// Define CLEAR_SCREEN_EN to add a full-screen clear that has priority over box requests.
module box_plot_scheduler #(
    parameter int NREQ  = 2,
    parameter int BOX_W = 4,
    parameter int BOX_H = 4,
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   req_x,
    input  logic [7*NREQ-1:0]   req_y,
    input  logic [3*NREQ-1:0]   req_colour,
    input  logic                clear_req,
    input  logic [2:0]          clear_colour,
    output logic [NREQ-1:0]     grant,
    output logic [NREQ-1:0]     done,
    output logic [7:0]          oX,
    output logic [6:0]          oY,
    output logic [2:0]          oColour,
    output logic                oPlot,
    output logic                busy
);

    localparam int              IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [2:0]      PX_LAST  = 3'(BOX_W - 1);
    localparam logic [2:0]      PY_LAST  = 3'(BOX_H - 1);
    localparam logic [8:0]      X_LIM    = 9'(X_MAX);
    localparam logic [7:0]      Y_LIM    = 8'(Y_MAX);
    localparam logic [IW-1:0]   WIN_LAST = IW'(NREQ - 1);

`ifdef CLEAR_SCREEN_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_DRAW  = 3'd2,
        S_DONE  = 3'd3,
        S_CLEAR = 3'd4
    } state_t;
    localparam logic [7:0] CX_LAST = 8'(X_MAX);
    localparam logic [6:0] CY_LAST = 7'(Y_MAX);
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LATCH = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;
`endif

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    state_t             r_state, w_state_nxt;
    logic [IW-1:0]      r_rr, w_rr_nxt;
    logic [IW-1:0]      r_win, w_win_nxt;
    logic [7:0]         r_bx, w_bx_nxt;
    logic [6:0]         r_by, w_by_nxt;
    logic [2:0]         r_col, w_col_nxt;
    logic [2:0]         r_px, w_px_nxt;
    logic [2:0]         r_py, w_py_nxt;
    logic [NREQ-1:0]    r_grant, w_grant_nxt;
    logic [NREQ-1:0]    r_done, w_done_nxt;
    logic [7:0]         r_ox, w_ox_nxt;
    logic [6:0]         r_oy, w_oy_nxt;
    logic [2:0]         r_ocol, w_ocol_nxt;
    logic               r_oplot, w_plot_nxt;
    logic               r_busy, w_busy_nxt;
    logic               w_emit;
    logic [8:0]         w_sum_x;
    logic [7:0]         w_sum_y;

    int                 w_idx;
    logic               w_found;
    logic [IW-1:0]      w_pick;
    logic [7:0]         w_sel_x;
    logic [6:0]         w_sel_y;
    logic [2:0]         w_sel_col;

`ifdef CLEAR_SCREEN_EN
    logic [7:0]         r_cx, w_cx_nxt;
    logic [6:0]         r_cy, w_cy_nxt;
    logic [2:0]         r_ccol, w_ccol_nxt;
    logic               w_cemit;
`else
    logic               w_unused_clear;
    assign w_unused_clear = ^{clear_req, clear_colour};
`endif

    // Round-robin pick: first set req at or above r_rr, wrapping, then mux its box data.
    always_comb begin
        w_found   = 1'b0;
        w_pick    = '0;
        w_idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx   = int'(r_rr) + k;
            w_idx   = (w_idx >= NREQ) ? (w_idx - NREQ) : w_idx;
            w_pick  = (!w_found && req[IW'(w_idx)]) ? IW'(w_idx) : w_pick;
            w_found = w_found | req[IW'(w_idx)];
        end
        w_sel_x   = 8'd0;
        w_sel_y   = 7'd0;
        w_sel_col = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            w_sel_x   = w_sel_x   | (req_x[8*i +: 8]      & {8{w_pick == IW'(i)}});
            w_sel_y   = w_sel_y   | (req_y[7*i +: 7]      & {7{w_pick == IW'(i)}});
            w_sel_col = w_sel_col | (req_colour[3*i +: 3] & {3{w_pick == IW'(i)}});
        end
    end

    // Next-state and next-output logic; pixel outputs are computed for the next cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        w_win_nxt   = r_win;
        w_bx_nxt    = r_bx;
        w_by_nxt    = r_by;
        w_col_nxt   = r_col;
        w_px_nxt    = r_px;
        w_py_nxt    = r_py;
        w_grant_nxt = '0;
        w_done_nxt  = '0;
        w_emit      = 1'b0;
`ifdef CLEAR_SCREEN_EN
        w_cx_nxt    = r_cx;
        w_cy_nxt    = r_cy;
        w_ccol_nxt  = r_ccol;
        w_cemit     = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
`ifdef CLEAR_SCREEN_EN
                if (clear_req) begin
                    w_state_nxt = S_CLEAR;
                    w_cx_nxt    = 8'd0;
                    w_cy_nxt    = 7'd0;
                    w_ccol_nxt  = clear_colour;
                    w_cemit     = 1'b1;
                end else
`endif
                if (w_found) begin
                    w_state_nxt = S_LATCH;
                    w_win_nxt   = w_pick;
                    w_bx_nxt    = w_sel_x;
                    w_by_nxt    = w_sel_y;
                    w_col_nxt   = w_sel_col;
                    w_px_nxt    = 3'd0;
                    w_py_nxt    = 3'd0;
                    w_grant_nxt = onehot(w_pick);
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LATCH: begin
                w_state_nxt = S_DRAW;
                w_px_nxt    = 3'd0;
                w_py_nxt    = 3'd0;
                w_grant_nxt = onehot(r_win);
                w_emit      = 1'b1;
            end
            S_DRAW: begin
                w_grant_nxt = onehot(r_win);
                if ((r_px == PX_LAST) && (r_py == PY_LAST)) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = onehot(r_win);
                    w_rr_nxt    = (r_win == WIN_LAST) ? '0 : (r_win + IW'(1));
                end else if (r_px == PX_LAST) begin
                    w_px_nxt = 3'd0;
                    w_py_nxt = r_py + 3'd1;
                    w_emit   = 1'b1;
                end else begin
                    w_px_nxt = r_px + 3'd1;
                    w_emit   = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
`ifdef CLEAR_SCREEN_EN
            S_CLEAR: begin
                if ((r_cx == CX_LAST) && (r_cy == CY_LAST)) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cx == CX_LAST) begin
                    w_cx_nxt = 8'd0;
                    w_cy_nxt = r_cy + 7'd1;
                    w_cemit  = 1'b1;
                end else begin
                    w_cx_nxt = r_cx + 8'd1;
                    w_cemit  = 1'b1;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Widened sums so off-screen pixels are clipped instead of wrapping.
        w_sum_x    = {1'b0, r_bx} + {6'd0, w_px_nxt};
        w_sum_y    = {1'b0, r_by} + {5'd0, w_py_nxt};
        w_ox_nxt   = r_ox;
        w_oy_nxt   = r_oy;
        w_ocol_nxt = r_ocol;
        w_plot_nxt = 1'b0;
        if (w_emit) begin
            w_ox_nxt   = w_sum_x[7:0];
            w_oy_nxt   = w_sum_y[6:0];
            w_ocol_nxt = r_col;
            w_plot_nxt = (w_sum_x <= X_LIM) && (w_sum_y <= Y_LIM);
        end
`ifdef CLEAR_SCREEN_EN
        else if (w_cemit) begin
            w_ox_nxt   = w_cx_nxt;
            w_oy_nxt   = w_cy_nxt;
            w_ocol_nxt = w_ccol_nxt;
            w_plot_nxt = 1'b1;
        end
`endif
        else begin
            w_plot_nxt = 1'b0;
        end
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_rr    <= '0;
            r_win   <= '0;
            r_bx    <= 8'd0;
            r_by    <= 7'd0;
            r_col   <= 3'd0;
            r_px    <= 3'd0;
            r_py    <= 3'd0;
            r_grant <= '0;
            r_done  <= '0;
            r_ox    <= 8'd0;
            r_oy    <= 7'd0;
            r_ocol  <= 3'd0;
            r_oplot <= 1'b0;
            r_busy  <= 1'b0;
`ifdef CLEAR_SCREEN_EN
            r_cx    <= 8'd0;
            r_cy    <= 7'd0;
            r_ccol  <= 3'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_rr    <= w_rr_nxt;
            r_win   <= w_win_nxt;
            r_bx    <= w_bx_nxt;
            r_by    <= w_by_nxt;
            r_col   <= w_col_nxt;
            r_px    <= w_px_nxt;
            r_py    <= w_py_nxt;
            r_grant <= w_grant_nxt;
            r_done  <= w_done_nxt;
            r_ox    <= w_ox_nxt;
            r_oy    <= w_oy_nxt;
            r_ocol  <= w_ocol_nxt;
            r_oplot <= w_plot_nxt;
            r_busy  <= w_busy_nxt;
`ifdef CLEAR_SCREEN_EN
            r_cx    <= w_cx_nxt;
            r_cy    <= w_cy_nxt;
            r_ccol  <= w_ccol_nxt;
`endif
        end
    end

    assign grant   = r_grant;
    assign done    = r_done;
    assign oX      = r_ox;
    assign oY      = r_oy;
    assign oColour = r_ocol;
    assign oPlot   = r_oplot;
    assign busy    = r_busy;

endmodule
